// File: rtl/voting_pkg.sv
// Shared definitions for the vote collector and the combinational voting block.
package voting_pkg;
    localparam int VOTE_N     = 3;
    localparam int VOTE_M     = 3;
    localparam int NUM_VOTERS = 2**VOTE_M;

    typedef enum logic {COLLECT, PRESENT} state_t;

    // Low bit of voter slot i in a bus packed with n-bit ballots.
    function automatic int slot_lo(input int i, input int n);
        return i * n;
    endfunction
endpackage

// File: rtl/vote_timeout_ctr.sv
// Round timeout counter: starts on the first ballot of a round and flags
// expiry on the edge where it reaches TIMEOUT. Built only with VOTE_TIMEOUT_EN.
`ifdef VOTE_TIMEOUT_EN
module vote_timeout_ctr
    import voting_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clr,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic          running;
    logic [CW-1:0] cnt;

    // cnt holds the number of edges since the first accept; the next edge
    // brings it to TIMEOUT, so that is the edge the round closes on.
    assign expire = running && (cnt == CW'(TIMEOUT - 1));

    // Arm on first ballot, count while armed, drop when the round leaves COLLECT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (clr) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (running) begin
            cnt <= cnt + CW'(1);
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
        end
    end
endmodule
`endif

// File: rtl/vote_collector.sv
// Ballot collector feeding the voting block. Gathers one ballot per voter,
// then presents the packed bus until the consumer takes it.
// Optional: VOTE_TIMEOUT_EN closes a round TIMEOUT cycles after its first ballot.
module vote_collector
    import voting_pkg::*;
#(
    parameter int N       = VOTE_N,
    parameter int M       = VOTE_M,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [M-1:0]       in_voter_id,
    input  logic [N-1:0]       in_vote,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [(2**M)*N-1:0] vote,
    output logic [M:0]         vote_count,
    output logic               dup_err
);
    localparam int NV = 2**M;
    localparam logic [M:0] LAST_CNT = (M+1)'(NV - 1);

    state_t        state, state_next;
    logic [NV-1:0] mask;
    logic          accept, is_new, last, take, expire;

    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == PRESENT);
    assign accept    = in_valid && in_ready;
    assign is_new    = !mask[in_voter_id];
    assign last      = accept && is_new && (vote_count == LAST_CNT);
    assign take      = out_valid && out_ready;

`ifdef VOTE_TIMEOUT_EN
    vote_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept),
        .clr    (state == PRESENT),
        .expire (expire)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT;
    assign expire     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_next;
    end

    // Close the round on the last ballot (or expiry); reopen when taken.
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (last || expire) state_next = PRESENT;
            PRESENT: if (take)           state_next = COLLECT;
            default:                     state_next = COLLECT;
        endcase
    end

    // Slot storage: first ballot per voter wins, cleared when the round is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask       <= '0;
            vote       <= '0;
            vote_count <= '0;
            dup_err    <= 1'b0;
        end else begin
            dup_err <= accept && !is_new;
            if (take) begin
                mask       <= '0;
                vote       <= '0;
                vote_count <= '0;
            end else if (accept && is_new) begin
                mask[in_voter_id]                               <= 1'b1;
                vote[slot_lo(int'(in_voter_id), N) +: N]        <= in_vote;
                vote_count                                      <= vote_count + (M+1)'(1);
            end
        end
    end
endmodule
